// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit add slice with carry in and carry out.
module nibble_add_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one nibble per clock, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             c_out_reg;
    logic             out_valid_reg;
    logic [IDX_W-1:0] idx;
    logic [NIB_W-1:0] nib;
    logic             carry;

    nibble_add_slice u_slice (
        .a     (a_reg[{idx, 2'b00} +: NIB_W]),
        .b     (b_reg[{idx, 2'b00} +: NIB_W]),
        .c_in  (carry_reg),
        .sum   (nib),
        .c_out (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            c_out_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 2'b00} +: NIB_W] <= nib;
                    carry_reg <= carry;
                    idx       <= idx + 1'b1;
                    if (idx == LAST) begin
                        c_out_reg     <= carry;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for the nibble-serial adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        c_in4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic [3:0]  sum4;
    logic        c_out4;
    logic        busy4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .c_out     (c_out4),
        .busy      (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand set, then count cycles until out_valid (-1 on timeout).
    task automatic start16(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, output int cyc);
        a = av;
        b = bv;
        c_in = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy, c_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b cout=%b sum=%h want 1 0 0 0 0000",
                     in_ready, out_valid, busy, c_out, sum);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4, sum4} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL reset4: rdy=%b vld=%b busy=%b sum=%h want 1 0 0 0",
                     in_ready4, out_valid4, busy4, sum4);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        start16(16'h1234, 16'h4321, 1'b0, cyc);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 4", cyc);
        end
        checks++;
        if ({c_out, sum} !== {1'b0, 16'h5555}) begin
            failures++;
            $display("FAIL basic_sum: got %b_%h want 0_5555", c_out, sum);
        end
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            failures++;
            $display("FAIL basic_done_flags: rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL basic_handoff: rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        start16(16'hFFFF, 16'h0000, 1'b1, cyc);
        checks++;
        if (cyc !== 4 || {c_out, sum} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL ripple: cyc=%0d got %b_%h want 4 1_0000", cyc, c_out, sum);
        end
        tick();
    endtask

    task automatic test_max();
        int cyc;
        start16(16'hFFFF, 16'hFFFF, 1'b1, cyc);
        checks++;
        if (cyc !== 4 || {c_out, sum} !== {1'b1, 16'hFFFF}) begin
            failures++;
            $display("FAIL max: cyc=%0d got %b_%h want 4 1_ffff", cyc, c_out, sum);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        start16(16'h00FF, 16'h0001, 1'b0, cyc);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL bp_latency: got %0d want 4", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 2) begin
                a = 16'h1234;
                b = 16'h1111;
                c_in = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if ({out_valid, in_ready, c_out, sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b got %b_%h want 1 0 0_0100",
                         i, out_valid, in_ready, c_out, sum);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, busy, c_out, sum} !== {1'b0, 1'b0, 1'b0, 16'h0100}) begin
            failures++;
            $display("FAIL bp_handoff: vld=%b busy=%b got %b_%h want 0 0 0_0100",
                     out_valid, busy, c_out, sum);
        end
        tick();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL bp_single: vld=%b busy=%b rdy=%b want 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        a = 16'hAAAA;
        b = 16'h5555;
        c_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, c_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b cout=%b sum=%h want 1 0 0 0 0000",
                     in_ready, out_valid, busy, c_out, sum);
        end
        #1;
        rst_n = 1'b1;
        tick();
        start16(16'h0009, 16'h000D, 1'b0, cyc);
        checks++;
        if (cyc !== 4 || {c_out, sum} !== {1'b0, 16'h0016}) begin
            failures++;
            $display("FAIL after_reset: cyc=%0d got %b_%h want 4 0_0016", cyc, c_out, sum);
        end
        tick();
    endtask

    task automatic test_width4();
        int cyc;
        a4 = 4'h9;
        b4 = 4'hD;
        c_in4 = 1'b0;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!out_valid4) cyc = -1;
        checks++;
        if (cyc !== 1) begin
            failures++;
            $display("FAIL w4_latency: got %0d want 1", cyc);
        end
        checks++;
        if ({c_out4, sum4} !== {1'b1, 4'h6}) begin
            failures++;
            $display("FAIL w4_sum: got %b_%h want 1_6", c_out4, sum4);
        end
        tick();
        checks++;
        if ({out_valid4, in_ready4} !== 2'b01) begin
            failures++;
            $display("FAIL w4_handoff: vld=%b rdy=%b want 0 1", out_valid4, in_ready4);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_ripple();
        test_max();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
